// File: rtl/alu_arbiter.sv
// Two-client arbiter/sequencer sharing one combinational ALU: IDLE -> EXEC -> RESP.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module alu_arbiter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [3:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [3:0]   req1_op,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_op,
  input  logic [N-1:0] alu_y,
  input  logic [4:0]   alu_status,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_y,
  output logic [4:0]   rsp_status
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       state_reg, state_next;
  logic [N-1:0] a_reg, b_reg, y_reg;
  logic [3:0]   op_reg;
  logic [4:0]   status_reg;
  logic         id_reg;
  logic         any_valid;
  logic         winner;
  logic         grant;

  assign any_valid = req0_valid | req1_valid;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign winner = ~req0_valid;
`else
  logic last_grant_reg;

  // On contention the requester that did not win last time goes first.
  assign winner = (req0_valid & req1_valid) ? ~last_grant_reg : req1_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_reg <= 1'b1;
    end else if (grant) begin
      last_grant_reg <= winner;
    end
  end
`endif

  always_comb begin
    state_next = state_reg;
    grant      = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_valid) begin
          grant      = 1'b1;
          req0_ready = ~winner;
          req1_ready = winner;
          state_next = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      id_reg     <= 1'b0;
      y_reg      <= '0;
      status_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (grant) begin
        a_reg  <= winner ? req1_a  : req0_a;
        b_reg  <= winner ? req1_b  : req0_b;
        op_reg <= winner ? req1_op : req0_op;
        id_reg <= winner;
      end
      // The ALU has had the whole EXEC cycle to settle on the held operands.
      if (state_reg == EXEC) begin
        y_reg      <= alu_y;
        status_reg <= alu_status;
      end
    end
  end

  assign alu_a      = a_reg;
  assign alu_b      = b_reg;
  assign alu_op     = op_reg;
  assign rsp_valid  = (state_reg == RESP);
  assign rsp_id     = id_reg;
  assign rsp_y      = y_reg;
  assign rsp_status = status_reg;

endmodule
